// File: rtl/mod_seq_pkg.sv
// Shared types and constants for the DDS modulation sequencer.
// Holds the FSM state encoding, the select codes and the LFSR step function.
package mod_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [1:0] MOD_ASK  = 2'b00;
    localparam logic [1:0] MOD_FSK  = 2'b01;
    localparam logic [1:0] MOD_BPSK = 2'b10;
    localparam logic [1:0] MOD_LFSR = 2'b11;

    localparam logic [1:0] SIG_SIN = 2'b00;
    localparam logic [1:0] SIG_COS = 2'b01;
    localparam logic [1:0] SIG_SQU = 2'b10;
    localparam logic [1:0] SIG_SAW = 2'b11;

    // x^5+x^3+1 Fibonacci step; the new bit enters at position 0.
    function automatic logic [4:0] lfsr5_next(input logic [4:0] q);
        return {q[3:0], q[4] ^ q[2]};
    endfunction

endpackage

// File: rtl/mod_sequencer_lfsr5.sv
// 5-bit maximal-length LFSR that advances only when adv is high.
// The seed is loaded on reset and must be nonzero.
module lfsr5
    import mod_seq_pkg::*;
#(
    parameter logic [4:0] SEED = 5'b00001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [4:0] q
);

    logic [4:0] q_q;
    logic [4:0] q_d;

    // Next-state: step on adv, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (adv) begin
            q_d = lfsr5_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mod_sequencer.sv
// Symbol-timing sequencer for the DDS modulation path: counts sampler ticks,
// advances the data LFSR per symbol and applies config only at symbol boundaries.
module mod_sequencer
    import mod_seq_pkg::*;
#(
    parameter int unsigned         SYMBOL_TICKS = 50,
    parameter logic [4:0]          LFSR_SEED    = 5'b00001,
    parameter int unsigned         TW_WIDTH     = 32,
    parameter logic [TW_WIDTH-1:0] TW_F0        = 32'd258,
    parameter logic [TW_WIDTH-1:0] TW_F1        = 32'd1031
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sampler,
    input  logic                cfg_valid,
    input  logic [1:0]          cfg_mod_sel,
    input  logic [1:0]          cfg_sig_sel,
    output logic                cfg_ready,
    output logic [1:0]          modulation_sel,
    output logic [1:0]          signal_sel,
    output logic                lfsr,
    output logic [TW_WIDTH-1:0] phase_inc,
    output logic                symbol_strobe
);

    localparam int unsigned CNT_W = (SYMBOL_TICKS > 2) ? $clog2(SYMBOL_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_TICKS - 1);

    logic samp_meta_q, samp_sync_q, samp_prev_q, samp_tick_q;
    logic samp_tick_d;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                pend_q, pend_d;
    logic [1:0]          pend_mod_q, pend_mod_d;
    logic [1:0]          pend_sig_q, pend_sig_d;
    logic [1:0]          mod_sel_q, mod_sel_d;
    logic [1:0]          sig_sel_q, sig_sel_d;
    logic [TW_WIDTH-1:0] phase_inc_q, phase_inc_d;
    logic                strobe_q, strobe_d;

    logic                adv_s;
    logic                cfg_accept_s;
    logic                boundary_s;
    logic [4:0]          lfsr_vec_s;
    logic [4:0]          lfsr_nxt_s;

    assign cfg_ready    = ~pend_q;
    assign cfg_accept_s = cfg_valid & ~pend_q;
    assign boundary_s   = samp_tick_q & (tick_cnt_q == CNT_LAST);

    // Edge detect on the synchronised sampler level, registered into a 1-cycle tick.
    always_comb begin
        samp_tick_d = samp_sync_q & ~samp_prev_q;
    end

    // Sampler synchroniser, edge history and tick register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_meta_q <= 1'b0;
            samp_sync_q <= 1'b0;
            samp_prev_q <= 1'b0;
            samp_tick_q <= 1'b0;
        end else begin
            samp_meta_q <= sampler;
            samp_sync_q <= samp_meta_q;
            samp_prev_q <= samp_sync_q;
            samp_tick_q <= samp_tick_d;
        end
    end

    // FSM next-state, tick counting and config staging.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pend_d     = pend_q;
        pend_mod_d = pend_mod_q;
        pend_sig_d = pend_sig_q;
        mod_sel_d  = mod_sel_q;
        sig_sel_d  = sig_sel_q;
        strobe_d   = 1'b0;
        adv_s      = 1'b0;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (cfg_accept_s) begin
                    mod_sel_d = cfg_mod_sel;
                    sig_sel_d = cfg_sig_sel;
                end else begin
                    mod_sel_d = mod_sel_q;
                end
                if (en) begin
                    state_d = ALIGN;
                end else begin
                    state_d = IDLE;
                end
            end

            ALIGN, RUN: begin
                if (!en) begin
                    // Leaving the run: anything staged takes effect now, the LFSR is held.
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    pend_d     = 1'b0;
                    if (pend_q) begin
                        mod_sel_d = pend_mod_q;
                        sig_sel_d = pend_sig_q;
                    end else if (cfg_accept_s) begin
                        mod_sel_d = cfg_mod_sel;
                        sig_sel_d = cfg_sig_sel;
                    end else begin
                        mod_sel_d = mod_sel_q;
                    end
                end else if (state_q == ALIGN) begin
                    if (samp_tick_q) begin
                        state_d    = RUN;
                        tick_cnt_d = '0;
                    end else begin
                        state_d = ALIGN;
                    end
                    if (cfg_accept_s) begin
                        pend_d     = 1'b1;
                        pend_mod_d = cfg_mod_sel;
                        pend_sig_d = cfg_sig_sel;
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (boundary_s) begin
                    tick_cnt_d = '0;
                    adv_s      = 1'b1;
                    strobe_d   = 1'b1;
                    pend_d     = 1'b0;
                    // A same-cycle accept is applied here directly and never raises pending.
                    if (pend_q) begin
                        mod_sel_d = pend_mod_q;
                        sig_sel_d = pend_sig_q;
                    end else if (cfg_accept_s) begin
                        mod_sel_d = cfg_mod_sel;
                        sig_sel_d = cfg_sig_sel;
                    end else begin
                        mod_sel_d = mod_sel_q;
                    end
                end else begin
                    if (samp_tick_q) begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end else begin
                        tick_cnt_d = tick_cnt_q;
                    end
                    if (cfg_accept_s) begin
                        pend_d     = 1'b1;
                        pend_mod_d = cfg_mod_sel;
                        pend_sig_d = cfg_sig_sel;
                    end else begin
                        pend_d = pend_q;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                pend_d     = 1'b0;
            end
        endcase
    end

    lfsr5 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (adv_s),
        .q     (lfsr_vec_s)
    );

    // Tuning word from next-state select and bit so it moves with them.
    always_comb begin
        lfsr_nxt_s = adv_s ? lfsr5_next(lfsr_vec_s) : lfsr_vec_s;
        if ((mod_sel_d == MOD_FSK) && lfsr_nxt_s[0]) begin
            phase_inc_d = TW_F1;
        end else begin
            phase_inc_d = TW_F0;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_mod_q  <= MOD_ASK;
            pend_sig_q  <= SIG_SIN;
            mod_sel_q   <= MOD_ASK;
            sig_sel_q   <= SIG_SIN;
            phase_inc_q <= TW_F0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            pend_q      <= pend_d;
            pend_mod_q  <= pend_mod_d;
            pend_sig_q  <= pend_sig_d;
            mod_sel_q   <= mod_sel_d;
            sig_sel_q   <= sig_sel_d;
            phase_inc_q <= phase_inc_d;
            strobe_q    <= strobe_d;
        end
    end

    assign modulation_sel = mod_sel_q;
    assign signal_sel     = sig_sel_q;
    assign lfsr           = lfsr_vec_s[0];
    assign phase_inc      = phase_inc_q;
    assign symbol_strobe  = strobe_q;

endmodule
